// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave front end.
//   state_e     - frame FSM states
//   OP_*        - opcode field values carried in rx_data[9:8]
//   FrameLen    - command word bits shifted in per frame
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StSend
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int unsigned FrameLen = 10;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the RAM-side command/read-data handshake.
//   SS_n, MOSI, MISO   - SPI bus (MSB first, bit clock = system clock)
//   rx_data, rx_valid  - command word strobe towards the RAM
//   tx_data, tx_valid  - read byte returned by the RAM
// Modports: slave (the spi_slave block), master (SPI master + RAM side).
interface spi_slave_if #(
  parameter int unsigned WORD_SIZE = 8
);

  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [WORD_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: parallel-load, MSB-first output shifter for MISO.
//   clk, rst  - system clock, synchronous active-high reset
//   clear     - frame abort; empties the shifter and forces miso low
//   load      - capture din; first bit appears on miso one edge later
//   din       - parallel read byte
//   miso      - registered serial output, 0 when idle
//   done      - no bits left to send
module spi_tx_serializer import spi_slave_pkg::*; #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] din,
  output logic             miso,
  output logic             done
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] sh_q;
  logic [CntW-1:0]  cnt_q;
  logic             miso_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else if (load) begin
      sh_q  <= din;
      cnt_q <= CntW'(Width);
    end else if (cnt_q != '0) begin
      miso_q <= sh_q[Width-1];
      sh_q   <= {sh_q[Width-2:0], 1'b0};
      cnt_q  <= cnt_q - CntW'(1);
    end else begin
      // Last bit has been on the line for one cycle; return to idle level.
      miso_q <= 1'b0;
    end
  end

  assign miso = miso_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI-to-RAM command front end.
//   clk  - system clock, also the SPI bit clock
//   rst  - synchronous active-high reset
//   bus  - spi_slave_if.slave: SS_n/MOSI/MISO towards the master,
//          rx_data/rx_valid command words and tx_data/tx_valid read bytes
//          towards the RAM
// Each frame: one routing bit (0 write, 1 read) then a FrameLen-bit command
// word. Read frames alternate between address and data via rd_addr_done_q;
// a completed read-data frame waits for tx_valid and then shifts the byte
// out on MISO.
module spi_slave import spi_slave_pkg::*; #(
  parameter int unsigned WORD_SIZE = 8
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned CmdW = WORD_SIZE + 2;
  localparam int unsigned CntW = $clog2(FrameLen);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameLen - 1);

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [CmdW-2:0] shift_q;
  logic            word_done_q;
  logic [CmdW-1:0] rx_data_q;
  logic            rx_valid_q;
  logic            rd_addr_done_q;

  logic tx_accept;
  logic tx_idle;
  logic miso;

  // Read byte is only taken once the command word has been strobed out and
  // the strobe cycle itself is over.
  assign tx_accept = (state_q == StReadData) && word_done_q && !rx_valid_q &&
                     bus.tx_valid && tx_idle && !bus.SS_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      word_done_q    <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else if (bus.SS_n) begin
      // Abort: drop any partial frame without strobing rx_valid.
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StChkCmd;

        StChkCmd: begin
          if (!bus.MOSI) begin
            state_q <= StWrite;
          end else if (rd_addr_done_q) begin
            state_q <= StReadData;
          end else begin
            state_q <= StReadAdd;
          end
        end

        StWrite, StReadAdd, StReadData: begin
          if (!word_done_q) begin
            shift_q <= {shift_q[CmdW-3:0], bus.MOSI};
            if (bit_cnt_q == LastBit) begin
              rx_data_q   <= {shift_q, bus.MOSI};
              rx_valid_q  <= 1'b1;
              bit_cnt_q   <= '0;
              word_done_q <= 1'b1;
              if (state_q == StReadAdd) begin
                rd_addr_done_q <= 1'b1;
              end else if (state_q == StReadData) begin
                rd_addr_done_q <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (tx_accept) begin
            state_q <= StSend;
          end
        end

        // Serializer runs on its own; hold here until SS_n rises.
        StSend: state_q <= StSend;

        default: state_q <= StIdle;
      endcase
    end
  end

  spi_tx_serializer #(
    .Width(WORD_SIZE)
  ) u_tx_serializer (
    .clk  (clk),
    .rst  (rst),
    .clear(bus.SS_n),
    .load (tx_accept),
    .din  (bus.tx_data),
    .miso (miso),
    .done (tx_idle)
  );

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
